dual_puf_crp_engine: RTL and testbench
======================================

Name: dual_puf_crp_engine

Overview:
Sequenced challenge-response engine for the dual-mode PUF core. It expands an N-bit seed challenge into a stream of challenges with an LFSR. For each challenge it fires the PUF VOTES times and majority-votes the sampled response bit. Voted bits are packed into a RESP_W-bit word, delivered with a valid/ready handshake and a count of unstable bits. It sits between the PUF core (drives its `in`/`sel`, reads its `out`) and the key/ID logic.

Parameters:
N, 128, challenge width (width of puf_sel and seed)
RESP_W, 32, response bits per run
VOTES, 5, evaluations per bit; must be odd and >= 1
SETTLE, 4, cycles puf_in is held high before sampling; >= 1
TAP_MASK, dual_puf_pkg::DEF_TAPS, LFSR feedback mask (N bits)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start  input  1  run request; sampled only in IDLE
mode  input  1  PUF mode (0 arbiter, 1 RO); latched at start
seed  input  N  first challenge; latched at start
busy  output  1  high from accepted start until handshake completes
puf_mode  output  1  latched mode, driven to the PUF core
puf_sel  output  N  current challenge to the PUF core
puf_in  output  1  excitation to the PUF core
puf_out  input  1  PUF response bit
resp  output  RESP_W  voted response word; bit i = i-th evaluated challenge
resp_valid  output  1  response available
resp_ready  input  1  consumer accept
unstable_cnt  output  $clog2(RESP_W+1)  number of bits with non-unanimous votes

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0, FSM goes to IDLE, LFSR, vote counter and bit counter clear. Reset has priority in every state, including mid-run.
- FSM states: IDLE, FIRE, SETTLE, NEXT, DONE.
- IDLE:
  - start==1: latch mode and the challenge, set busy, go to FIRE.
  - The latched challenge is seed, or dual_puf_pkg::FALLBACK_SEED (all-ones) if seed==0.
- FIRE (1 cycle): puf_in=0, go to SETTLE.
- SETTLE (SETTLE cycles): puf_in=1.
  - On the last SETTLE cycle, sample puf_out: ones += puf_out, votes += 1.
  - If votes<VOTES, go to FIRE; else go to NEXT.
- NEXT (0-cycle merge into the last SETTLE edge):
  - bit = (ones > VOTES/2); written to resp[bitcnt].
  - If ones is neither 0 nor VOTES, unstable_cnt += 1.
  - Clear ones and votes, step the LFSR, bitcnt += 1.
  - If bitcnt==RESP_W-1, go to DONE; else go to FIRE.
- LFSR step: next = {cur[N-2:0], ^(cur & TAP_MASK)}. puf_sel shows the current challenge throughout FIRE/SETTLE.
- Latency: resp_valid rises exactly RESP_W*VOTES*(SETTLE+1)+1 cycles after the edge that accepts start.
- DONE:
  - resp_valid=1; resp and unstable_cnt are held stable; puf_in=0.
  - On resp_valid && resp_ready: next cycle resp_valid=0, busy=0, state IDLE.
  - resp, unstable_cnt and puf_sel keep their values until the next start.
- start while busy is ignored, including the handshake cycle; a new run needs start in IDLE.
- resp_ready with resp_valid==0 is ignored.
- mode and seed changes after acceptance are ignored.

Optional Feature:
PUF_STABLE_MASK_EN:
- When defined, adds output stable_mask[RESP_W-1:0]. Bit i = 1 iff the votes for bit i were unanimous. Reset to 0, written alongside resp, held in DONE.
- When undefined, the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package dual_puf_pkg:
  - state enum (IDLE, FIRE, SETTLE, NEXT, DONE)
  - DEF_TAPS (bits N-1, N-2, N-27, N-29 set for N=128)
  - FALLBACK_SEED
  - function cnt_w(RESP_W)
- One sub-module, puf_lfsr: parameters N and TAP_MASK; ports load, load_val, step, state.

Test Plan:
Bench configuration: N=8, RESP_W=4, VOTES=3, SETTLE=2, TAP_MASK=8'hB8. Expected latency is 37 cycles.
1. Hold reset=0 for 2 cycles -> busy, resp_valid, resp, puf_sel, puf_in, unstable_cnt all 0.
2. seed=8'h5A, puf_out stuck 1, start -> puf_sel=8'h5A during the first FIRE; resp_valid at cycle 37; resp=4'hF; unstable_cnt=0.
3. puf_out alternating 1,0,1,0,... per sample -> votes 101,010,101,010; resp=4'b0101; unstable_cnt=4.
4. seed=0, start -> first puf_sel=8'hFF; second challenge equals the LFSR step of 8'hFF under 8'hB8.
5. resp_ready=0 for 10 cycles in DONE, start pulsed -> resp_valid and resp stable, start ignored. Then resp_ready=1 -> resp_valid=0 and busy=0 on the next cycle.
6. reset=0 at cycle 15 of a run -> next cycle IDLE, puf_sel=0, puf_in=0; no resp_valid appears afterwards.

Source files
------------

// File: rtl/dual_puf_pkg.sv
`default_nettype none
// ==================================================================
// dual_puf_pkg: shared types, constants and helpers for the CRP engine
// Rev 1.0
// ==================================================================
package dual_puf_pkg;

    localparam int MAX_N = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRE   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Taps at bits N-1, N-2, N-27, N-29 for N=128
    localparam logic [MAX_N-1:0] DEF_TAPS =
        {1'b1, 1'b1, 24'b0, 1'b1, 1'b0, 1'b1, 99'b0};

    localparam logic [MAX_N-1:0] FALLBACK_SEED = '1;

    function automatic int cnt_w(input int resp_w);
        return $clog2(resp_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_puf_crp_engine_if.sv
`default_nettype none
// ==================================================================
// dual_puf_crp_engine_if: host and PUF-core signals of the CRP engine
// Optional: PUF_STABLE_MASK_EN adds stable_mask.  Rev 1.0
// ==================================================================
interface dual_puf_crp_engine_if
    import dual_puf_pkg::*;
#(
    parameter int N      = 128,
    parameter int RESP_W = 32
);
    localparam int CW = cnt_w(RESP_W);

    logic              start;
    logic              mode;
    logic [N-1:0]      seed;
    logic              busy;
    logic              puf_mode;
    logic [N-1:0]      puf_sel;
    logic              puf_in;
    logic              puf_out;
    logic [RESP_W-1:0] resp;
    logic              resp_valid;
    logic              resp_ready;
    logic [CW-1:0]     unstable_cnt;
`ifdef PUF_STABLE_MASK_EN
    logic [RESP_W-1:0] stable_mask;

    modport master (
        output start, mode, seed, puf_out, resp_ready,
        input  busy, puf_mode, puf_sel, puf_in, resp, resp_valid,
               unstable_cnt, stable_mask
    );
    modport slave (
        input  start, mode, seed, puf_out, resp_ready,
        output busy, puf_mode, puf_sel, puf_in, resp, resp_valid,
               unstable_cnt, stable_mask
    );
`else
    modport master (
        output start, mode, seed, puf_out, resp_ready,
        input  busy, puf_mode, puf_sel, puf_in, resp, resp_valid,
               unstable_cnt
    );
    modport slave (
        input  start, mode, seed, puf_out, resp_ready,
        output busy, puf_mode, puf_sel, puf_in, resp, resp_valid,
               unstable_cnt
    );
`endif

endinterface
`default_nettype wire

// File: rtl/dual_puf_crp_engine_lfsr.sv
`default_nettype none
// ==================================================================
// puf_lfsr: loadable Fibonacci LFSR producing the challenge sequence
// Rev 1.0
// ==================================================================
module puf_lfsr
    import dual_puf_pkg::*;
#(
    parameter int            N        = 128,
    parameter logic [N-1:0]  TAP_MASK = DEF_TAPS[N-1:0]
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         load,
    input  wire logic [N-1:0] load_val,
    input  wire logic         step,
    output logic      [N-1:0] state
);
    logic [N-1:0] state_q;
    logic [N-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = {state_q[N-2:0], ^(state_q & TAP_MASK)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/dual_puf_crp_engine.sv
`default_nettype none
// ==================================================================
// dual_puf_crp_engine: LFSR-sequenced, majority-voted PUF CRP engine
// Optional: PUF_STABLE_MASK_EN adds stable_mask.  Rev 1.0
// ==================================================================
module dual_puf_crp_engine
    import dual_puf_pkg::*;
#(
    parameter int           N        = 128,
    parameter int           RESP_W   = 32,
    parameter int           VOTES    = 5,
    parameter int           SETTLE   = 4,
    parameter logic [N-1:0] TAP_MASK = DEF_TAPS[N-1:0]
) (
    input  wire logic              clk,
    input  wire logic              reset,
    dual_puf_crp_engine_if.slave   bus
);
    localparam int VW = $clog2(VOTES + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int CW = cnt_w(RESP_W);

    state_t            state_q;
    logic [VW-1:0]     ones_q, votes_q, ones_d, votes_d;
    logic [SW-1:0]     settle_q;
    logic [BW-1:0]     bitcnt_q;
    logic [RESP_W-1:0] resp_q;
    logic [CW-1:0]     unst_q;
    logic              busy_q, valid_q, puf_in_q, mode_q;
    logic              vote_last, bit_d, unanimous_d, lfsr_load, lfsr_step;
    logic [N-1:0]      seed_d, chal;
`ifdef PUF_STABLE_MASK_EN
    logic [RESP_W-1:0] mask_q;
`endif

    always_comb begin
        ones_d      = ones_q + VW'(bus.puf_out);
        votes_d     = votes_q + VW'(1);
        vote_last   = (state_q == ST_SETTLE) && (settle_q == SW'(SETTLE - 1));
        bit_d       = ones_d > VW'(VOTES / 2);
        unanimous_d = (ones_d == '0) || (ones_d == VW'(VOTES));
        seed_d      = (bus.seed == '0) ? FALLBACK_SEED[N-1:0] : bus.seed;
        lfsr_load   = (state_q == ST_IDLE) && bus.start;
        lfsr_step   = vote_last && (votes_d == VW'(VOTES));
    end

    puf_lfsr #(.N(N), .TAP_MASK(TAP_MASK)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (seed_d),
        .step     (lfsr_step),
        .state    (chal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ones_q   <= '0;
            votes_q  <= '0;
            settle_q <= '0;
            bitcnt_q <= '0;
            resp_q   <= '0;
            unst_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            puf_in_q <= 1'b0;
            mode_q   <= 1'b0;
`ifdef PUF_STABLE_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        busy_q   <= 1'b1;
                        bitcnt_q <= '0;
                        resp_q   <= '0;
                        unst_q   <= '0;
`ifdef PUF_STABLE_MASK_EN
                        mask_q   <= '0;
`endif
                        state_q  <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    puf_in_q <= 1'b1;
                    settle_q <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!vote_last) begin
                        settle_q <= settle_q + SW'(1);
                    end else begin
                        puf_in_q <= 1'b0;
                        if (votes_d < VW'(VOTES)) begin
                            ones_q  <= ones_d;
                            votes_q <= votes_d;
                            state_q <= ST_FIRE;
                        end else begin
                            // Vote resolution folded into the last settle edge
                            resp_q[bitcnt_q] <= bit_d;
`ifdef PUF_STABLE_MASK_EN
                            mask_q[bitcnt_q] <= unanimous_d;
`endif
                            if (!unanimous_d) begin
                                unst_q <= unst_q + CW'(1);
                            end
                            ones_q   <= '0;
                            votes_q  <= '0;
                            bitcnt_q <= bitcnt_q + BW'(1);
                            state_q  <= (bitcnt_q == BW'(RESP_W - 1)) ? ST_DONE : ST_FIRE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.puf_mode     = mode_q;
    assign bus.puf_sel      = chal;
    assign bus.puf_in       = puf_in_q;
    assign bus.resp         = resp_q;
    assign bus.resp_valid   = valid_q;
    assign bus.unstable_cnt = unst_q;
`ifdef PUF_STABLE_MASK_EN
    assign bus.stable_mask  = mask_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_puf_crp_engine.sv
`default_nettype none
// ==================================================================
// tb_dual_puf_crp_engine: randomized self-checking bench, N=8 RESP_W=4
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
module tb_dual_puf_crp_engine;
    localparam int          N       = 8;
    localparam int          RESP_W  = 4;
    localparam int          VOTES   = 3;
    localparam int          SETTLE  = 2;
    localparam logic [N-1:0] TAPS   = 8'hB8;
    localparam int          PER     = SETTLE + 1;
    localparam int          SAMPLES = RESP_W * VOTES;
    localparam int          LAT     = SAMPLES * PER + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dual_puf_crp_engine_if #(.N(N), .RESP_W(RESP_W)) bus ();

    dual_puf_crp_engine #(
        .N(N), .RESP_W(RESP_W), .VOTES(VOTES), .SETTLE(SETTLE), .TAP_MASK(TAPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: one run is a sequence of LAT windows after accept
    bit                 known = 0, active = 0, zeroed = 0, held = 0;
    int                 cyc = 0;
    logic               m_mode = 1'b0;
    logic [N-1:0]       chal [RESP_W+1];
    logic [SAMPLES-1:0] pat = '0;
    logic [RESP_W-1:0]  e_resp = '0, e_mask = '0;
    int                 e_unst = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [N-1:0] lfsr_next(logic [N-1:0] x);
        return {x[N-2:0], ^(x & TAPS)};
    endfunction

    task automatic accept();
        int ones;
        active = 1; zeroed = 0; held = 0; cyc = 0;
        m_mode  = bus.mode;
        chal[0] = (bus.seed == '0) ? '1 : bus.seed;
        for (int b = 0; b < RESP_W; b++) chal[b+1] = lfsr_next(chal[b]);
        e_resp = '0; e_mask = '0; e_unst = 0;
        for (int b = 0; b < RESP_W; b++) begin
            ones = 0;
            for (int v = 0; v < VOTES; v++) ones += int'(pat[b*VOTES + v]);
            e_resp[b] = (2 * ones > VOTES);
            e_mask[b] = (ones == 0 || ones == VOTES);
            if (!e_mask[b]) e_unst++;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            known = 1; active = 0; zeroed = 1; held = 0;
        end else if (active) begin
            if (cyc >= LAT && bus.resp_ready) begin
                active = 0; held = 1;
            end else begin
                cyc++;
            end
        end else if (bus.start) begin
            accept();
        end
    end

    always @(negedge clk) begin
        if (known) begin
            if (active) begin
                chk("busy_run", bus.busy, 1);
                chk("puf_mode", bus.puf_mode, m_mode);
                if (cyc < LAT - 1) begin
                    chk("puf_sel", bus.puf_sel, chal[cyc / (VOTES * PER)]);
                    chk("puf_in", bus.puf_in, (cyc % PER) != 0);
                    chk("valid_early", bus.resp_valid, 0);
                end else begin
                    chk("puf_in_done", bus.puf_in, 0);
                    chk("puf_sel_done", bus.puf_sel, chal[RESP_W]);
                    chk("valid_done", bus.resp_valid, cyc >= LAT);
                    if (cyc >= LAT) begin
                        chk("resp", bus.resp, e_resp);
                        chk("unstable_cnt", bus.unstable_cnt, e_unst);
`ifdef PUF_STABLE_MASK_EN
                        chk("stable_mask", bus.stable_mask, e_mask);
`endif
                    end
                end
            end else if (zeroed) begin
                chk("rst_busy", bus.busy, 0);
                chk("rst_valid", bus.resp_valid, 0);
                chk("rst_resp", bus.resp, 0);
                chk("rst_sel", bus.puf_sel, 0);
                chk("rst_in", bus.puf_in, 0);
                chk("rst_unst", bus.unstable_cnt, 0);
                chk("rst_mode", bus.puf_mode, 0);
            end else if (held) begin
                chk("idle_busy", bus.busy, 0);
                chk("idle_valid", bus.resp_valid, 0);
                chk("idle_resp", bus.resp, e_resp);
                chk("idle_unst", bus.unstable_cnt, e_unst);
                chk("idle_sel", bus.puf_sel, chal[RESP_W]);
                chk("idle_in", bus.puf_in, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (active && cyc < LAT - 1) bus.puf_out = pat[cyc / PER];
        else bus.puf_out = 1'($urandom_range(0, 1));
    endtask

    task automatic start_run(logic [N-1:0] s, logic m, logic [SAMPLES-1:0] p);
        bus.seed  = s;
        bus.mode  = m;
        pat       = p;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.seed  = N'($urandom);
        bus.mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_run(int hold, bit poke);
        for (int i = 0; i < 2 * LAT && !(active && cyc >= LAT); i++) begin
            bus.resp_ready = (cyc < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus.resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus.resp_ready = 1'b1;
        bus.start      = poke;
        tick();
        bus.resp_ready = 1'b0;
        bus.start      = 1'b0;
        chk("hs_busy_low", bus.busy, 0);
        chk("hs_valid_low", bus.resp_valid, 0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [SAMPLES-1:0] alt;
        bus.start = 0; bus.mode = 0; bus.seed = '0; bus.puf_out = 0; bus.resp_ready = 0;
        for (int k = 0; k < SAMPLES; k++) alt[k] = (k % 2 == 0);

        // 1: reset
        reset = 1'b0;
        repeat (2) tick();
        chk("lit_rst_valid", bus.resp_valid, 0);
        reset = 1'b1;
        tick();

        // 2: stuck-at-1 response, latency pin
        start_run(8'h5A, 1'b1, '1);
        chk("lit_sel0", bus.puf_sel, 8'h5A);
        repeat (LAT - 1) tick();
        chk("lit_lat36", bus.resp_valid, 0);
        tick();
        chk("lit_lat37", bus.resp_valid, 1);
        chk("lit_resp_f", bus.resp, 4'hF);
        chk("lit_unst_0", bus.unstable_cnt, 0);
        finish_run(0, 0);

        // 3: alternating samples
        start_run(8'h33, 1'b0, alt);
        repeat (LAT) tick();
        chk("lit_resp_5", bus.resp, 4'b0101);
        chk("lit_unst_4", bus.unstable_cnt, 4);
        finish_run(0, 0);

        // 4 + 5: zero seed fallback, then long backpressure with start pokes
        start_run(8'h00, 1'b1, SAMPLES'($urandom));
        chk("lit_fallback", bus.puf_sel, 8'hFF);
        repeat (VOTES * PER) tick();
        chk("lit_second", bus.puf_sel, 8'hFE);
        finish_run(10, 1);

        // 6: reset mid-run
        start_run(8'hC3, 1'b1, SAMPLES'($urandom));
        repeat (15) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("lit_mid_busy", bus.busy, 0);
        chk("lit_mid_sel", bus.puf_sel, 0);
        chk("lit_mid_in", bus.puf_in, 0);
        repeat (LAT + 10) tick();
        chk("lit_mid_novalid", bus.resp_valid, 0);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            start_run(N'($urandom), 1'($urandom_range(0, 1)), SAMPLES'($urandom));
            finish_run($urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
